// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared word width, counter width and fetch-controller state encodings
package fetch_ctrl_pkg;
  localparam int WORD_W = 32;
  localparam int SEQ_CW = 16;
  typedef enum logic [2:0] {
    FC_RUN      = 3'd0,
    FC_STALL    = 3'd1,
    FC_REDIRECT = 3'd2,
    FC_FLUSH    = 3'd3,
    FC_DRAIN    = 3'd4,
    FC_HALT     = 3'd5
  } fc_state_e;
endpackage

// File: rtl/fetch_ctrl_down_counter.sv
// fetch_ctrl_down_counter: loadable down counter with zero flag, shared by stall/flush/drain sequencing
module fetch_ctrl_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  // load has priority over decrement; decrement stops at zero
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: Moore sequencing FSM for PC enable/select, redirect target and IF/ID flush/write controls
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH  = 3,
  parameter int STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              load_use,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_write,
  output logic              pc_src,
  output logic [WORD_W-1:0] redirect_pc,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              squash_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count
);
  localparam logic [SEQ_CW-1:0] STALL_LD = SEQ_CW'(STALL_CYCLES - 1);
  localparam logic [SEQ_CW-1:0] DRAIN_LD = SEQ_CW'(DRAIN_CYCLES - 1);
  localparam logic [SEQ_CW-1:0] FLUSH_LD = SEQ_CW'(FLUSH_DEPTH >= 2 ? FLUSH_DEPTH - 2 : 0);

  fc_state_e         state_q, state_d;
  logic [WORD_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  stall_count_q;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [SEQ_CW-1:0] cnt_ld_val;

  fetch_ctrl_down_counter #(.W(SEQ_CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_ld_val),
    .zero_o     (cnt_zero)
  );

  // next state, counter control and redirect latch; branch > halt > load-use
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    cnt_ld_val    = '0;
    case (state_q)
      FC_RUN: begin
        if (branch_taken) begin
          redirect_pc_d = branch_target;
          state_d       = FC_REDIRECT;
        end else if (halt_req) begin
          cnt_load   = 1'b1;
          cnt_ld_val = DRAIN_LD;
          state_d    = FC_DRAIN;
        end else if (load_use) begin
          cnt_load   = 1'b1;
          cnt_ld_val = STALL_LD;
          state_d    = FC_STALL;
        end
      end
      FC_STALL: begin
        if (branch_taken) begin
          redirect_pc_d = branch_target;
          state_d       = FC_REDIRECT;
        end else if (!cnt_zero) cnt_dec = 1'b1;
        else if (load_use) begin
          cnt_load   = 1'b1;
          cnt_ld_val = STALL_LD;
        end else state_d = FC_RUN;
      end
      FC_REDIRECT: begin
        cnt_load   = 1'b1;
        cnt_ld_val = FLUSH_LD;
        state_d    = (FLUSH_DEPTH <= 1) ? FC_RUN : FC_FLUSH;
      end
      FC_FLUSH: begin
        cnt_dec = 1'b1;
        state_d = cnt_zero ? FC_RUN : FC_FLUSH;
      end
      FC_DRAIN: begin
        if (branch_taken) begin
          redirect_pc_d = branch_target;
          state_d       = FC_REDIRECT;
        end else begin
          cnt_dec = 1'b1;
          state_d = cnt_zero ? FC_HALT : FC_DRAIN;
        end
      end
      FC_HALT: state_d = resume ? FC_RUN : FC_HALT;
      default: state_d = FC_RUN;
    endcase
  end

  // state and redirect target registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FC_RUN;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // saturating count of non-halt cycles with the PC frozen
  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else if (!pc_write && state_q != FC_HALT && stall_count_q != '1)
      stall_count_q <= stall_count_q + CNT_W'(1);
  end

  assign pc_write     = (state_q == FC_RUN) || (state_q == FC_REDIRECT) || (state_q == FC_FLUSH);
  assign pc_src       = (state_q == FC_REDIRECT);
  assign ifid_write   = (state_q != FC_STALL) && (state_q != FC_HALT);
  assign ifid_flush   = (state_q == FC_REDIRECT) || (state_q == FC_DRAIN);
  assign idex_flush   = (state_q == FC_STALL) || (state_q == FC_REDIRECT);
  assign squash_valid = (state_q != FC_REDIRECT) && (state_q != FC_FLUSH);
  assign halted       = (state_q == FC_HALT);
  assign redirect_pc  = redirect_pc_q;
  assign stall_count  = stall_count_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors with hand-computed expectations for fetch_ctrl
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset, branch_taken, load_use, halt_req, resume;
  logic [31:0] branch_target;
  logic        pc_write, pc_src, ifid_write, ifid_flush, idex_flush, squash_valid, halted;
  logic [31:0] redirect_pc, stall_count;
  int total = 0;
  int bad = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .branch_target(branch_target),
    .load_use(load_use), .halt_req(halt_req), .resume(resume), .pc_write(pc_write),
    .pc_src(pc_src), .redirect_pc(redirect_pc), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .squash_valid(squash_valid), .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; branch_taken = 0; branch_target = 0; load_use = 0; halt_req = 0; resume = 0;
    tick(); tick();
    chk("rst_pcw", pc_write, 1); chk("rst_src", pc_src, 0); chk("rst_sq", squash_valid, 1);
    chk("rst_cnt", stall_count, 0); chk("rst_halt", halted, 0); chk("rst_rpc", redirect_pc, 0);
    chk("rst_ifw", ifid_write, 1); chk("rst_iff", ifid_flush, 0); chk("rst_idf", idex_flush, 0);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_pcw", pc_write, 1); chk("idle_src", pc_src, 0);
      chk("idle_sq", squash_valid, 1); chk("idle_cnt", stall_count, 0);
    end
    // branch to 0x100: one REDIRECT, two FLUSH, then RUN
    branch_taken = 1; branch_target = 32'h100; tick(); branch_taken = 0; branch_target = 0;
    chk("br_src", pc_src, 1); chk("br_rpc", redirect_pc, 32'h100); chk("br_iff", ifid_flush, 1);
    chk("br_idf", idex_flush, 1); chk("br_sq0", squash_valid, 0); chk("br_pcw", pc_write, 1);
    tick(); chk("fl1_sq", squash_valid, 0); chk("fl1_src", pc_src, 0); chk("fl1_iff", ifid_flush, 0);
    tick(); chk("fl2_sq", squash_valid, 0);
    tick(); chk("run_sq", squash_valid, 1); chk("run_rpc", redirect_pc, 32'h100);
    // single load-use stall
    load_use = 1; tick(); load_use = 0;
    chk("st_pcw", pc_write, 0); chk("st_ifw", ifid_write, 0); chk("st_idf", idex_flush, 1);
    chk("st_sq", squash_valid, 1);
    tick(); chk("st_done_pcw", pc_write, 1); chk("st_cnt", stall_count, 1);
    // back-to-back stall: load_use held re-arms in the last stall cycle
    load_use = 1; tick(); chk("bb1_pcw", pc_write, 0);
    tick(); chk("bb2_pcw", pc_write, 0); load_use = 0;
    tick(); chk("bb_run", pc_write, 1); chk("bb_cnt", stall_count, 3);
    // branch beats load-use in the same cycle
    load_use = 1; branch_taken = 1; branch_target = 32'h40; tick();
    load_use = 0; branch_taken = 0; branch_target = 0;
    chk("pri_src", pc_src, 1); chk("pri_rpc", redirect_pc, 32'h40); chk("pri_cnt", stall_count, 3);
    tick(); tick(); tick();
    chk("pri_run", squash_valid, 1); chk("pri_cnt2", stall_count, 3); chk("pri_pcw", pc_write, 1);
    // halt: four DRAIN cycles then HALT
    halt_req = 1; tick(); halt_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk("dr_pcw", pc_write, 0); chk("dr_iff", ifid_flush, 1);
      chk("dr_sq", squash_valid, 1); chk("dr_halt", halted, 0);
      tick();
    end
    chk("h_halt", halted, 1); chk("h_pcw", pc_write, 0); chk("h_ifw", ifid_write, 0);
    chk("h_cnt", stall_count, 7);
    tick(); chk("h_hold", halted, 1); chk("h_cnt2", stall_count, 7);
    resume = 1; tick(); resume = 0;
    chk("res_halt", halted, 0); chk("res_pcw", pc_write, 1); chk("res_ifw", ifid_write, 1);
    // branch during DRAIN cycle 2 cancels the halt
    halt_req = 1; tick(); halt_req = 0; chk("dc1", halted, 0);
    tick(); chk("dc2_pcw", pc_write, 0);
    branch_taken = 1; branch_target = 32'h200; tick(); branch_taken = 0; branch_target = 0;
    chk("dc_src", pc_src, 1); chk("dc_rpc", redirect_pc, 32'h200); chk("dc_halt", halted, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("dc_nohalt", halted, 0);
    end
    chk("dc_pcw", pc_write, 1); chk("dc_cnt", stall_count, 9);
    // reset in the middle of FLUSH
    branch_taken = 1; branch_target = 32'h300; tick(); branch_taken = 0; branch_target = 0;
    tick(); chk("rf_sq0", squash_valid, 0);
    reset = 1; tick(); reset = 0;
    chk("rf_sq", squash_valid, 1); chk("rf_pcw", pc_write, 1); chk("rf_rpc", redirect_pc, 0);
    chk("rf_cnt", stall_count, 0); chk("rf_src", pc_src, 0);
    tick(); chk("rf_run", squash_valid, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the fetch stage: owns the PC write-enable, PC source select and redirect target, plus IF/ID write and stage-flush controls. Arbitrates three event sources (taken branch from MEM, load-use hazard from the hazard unit, HALT decode) into one Moore FSM. Sits beside the fetch stage. Drives the PC register enable, the PC mux `control`, the mux `b_in` target, and the pipeline-register flush/write pins.

Parameters:
FLUSH_DEPTH, 3, cycles squash_valid stays low after a redirect (wrong-path instructions in IF/ID/EX).
STALL_CYCLES, 1, bubble cycles inserted per load-use event (>=1).
DRAIN_CYCLES, 4, cycles to empty the pipeline after HALT decode before halted asserts.
CNT_W, 32, width of the stall performance counter.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high; one clock, clk
branch_taken  in  1  taken branch resolved in MEM this cycle
branch_target  in  `WORD  target address accompanying branch_taken
load_use  in  1  load-use hazard flag, registered by hazard unit
halt_req  in  1  HALT opcode decoded in ID
resume  in  1  leave HALT state
pc_write  out  1  PC register load enable
pc_src  out  1  PC mux select (1 = redirect_pc)
redirect_pc  out  `WORD  registered branch target to PC mux
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  zero IF/ID contents
idex_flush  out  1  insert bubble into ID/EX
squash_valid  out  1  0 while wrong-path instructions are in flight
halted  out  1  core stopped
stall_count  out  CNT_W  saturating count of cycles with pc_write=0 (excluding HALT)

Behaviour:
- All outputs are Moore (decoded from state/registers). Event-to-output latency is 1 cycle.
- States: RUN, STALL, REDIRECT, FLUSH, DRAIN, HALT. Reset places the FSM in RUN.
- Reset values: pc_write=1, pc_src=0, redirect_pc=0, ifid_write=1, ifid_flush=0, idex_flush=0, squash_valid=1, halted=0, stall_count=0, internal counters=0.
- Event priority in any state that samples events: branch_taken > halt_req > load_use.
- RUN: pc_write=1, ifid_write=1, no flushes.
  - branch_taken: latch branch_target into redirect_pc, go to REDIRECT.
  - halt_req: load cnt=DRAIN_CYCLES-1, go to DRAIN.
  - load_use: load cnt=STALL_CYCLES-1, go to STALL.
- STALL: pc_write=0, ifid_write=0, idex_flush=1.
  - cnt==0: return to RUN.
  - Otherwise decrement cnt.
  - branch_taken aborts the stall and goes to REDIRECT.
  - load_use re-sampled in the last STALL cycle reloads cnt (back-to-back stalls).
- REDIRECT (exactly 1 cycle): pc_src=1, pc_write=1, ifid_flush=1, idex_flush=1, squash_valid=0. Load cnt=FLUSH_DEPTH-2, then go to FLUSH. If FLUSH_DEPTH==1, go to RUN instead.
- FLUSH: pc_src=0, pc_write=1, ifid_write=1, squash_valid=0.
  - Decrement cnt; at cnt==0 go to RUN.
  - Net effect: squash_valid is low for exactly FLUSH_DEPTH cycles starting at REDIRECT.
- REDIRECT/FLUSH ignore branch_taken, load_use and halt_req, since these come from squashed instructions.
- DRAIN: pc_write=0, ifid_flush=1, squash_valid=1. Decrement cnt; at cnt==0 go to HALT.
  - branch_taken during DRAIN comes from an older instruction and must be honoured: cancel the halt, go to REDIRECT.
- HALT: pc_write=0, ifid_write=0, halted=1. resume goes to RUN. Other inputs are ignored.
- stall_count increments when pc_write=0 and state≠HALT. It holds at 2^CNT_W-1.
- redirect_pc updates only on an accepted branch_taken.
- Reset asserted in any state, mid-count included, returns to RUN with the reset values on the next edge.

Decomposition:
- Use `WORD from definitions.vh.
- Add state encodings (3-bit, FC_RUN..FC_HALT) to definitions.vh so the hazard unit and benches share them.
- Natural sub-module: down_counter (load, dec, zero flag, width param). It is reused for the stall, flush and drain counts.

Test Plan:
- Reset held 2 cycles then released, no events -> pc_write=1, pc_src=0, squash_valid=1, stall_count=0 every cycle.
- branch_taken=1 with target 0x100 for 1 cycle -> next cycle pc_src=1, redirect_pc=0x100, ifid_flush=1; squash_valid=0 for exactly 3 cycles; then RUN.
- load_use pulse (STALL_CYCLES=1) -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_count=1.
- load_use and branch_taken (target 0x40) in the same cycle -> REDIRECT to 0x40, no STALL cycle, stall_count unchanged.
- halt_req -> 4 DRAIN cycles, then halted=1. branch_taken (0x200) on DRAIN cycle 2 -> halt cancelled, redirect to 0x200, halted never 1.
- HALT reached, resume=1 -> RUN next cycle. Reset asserted during FLUSH -> RUN with squash_valid=1 next cycle.
